// File: rtl/multi_digit_display_driver.sv
// Binary value to multiplexed 7-segment display with leading-zero blanking.
// Define BRIGHTNESS_PWM_EN to add a 4-bit anode duty control (brightness).
module multi_digit_display_driver #(
  parameter int DIGITS       = 4,
  parameter int VALUE_WIDTH  = 14,
  parameter int REFRESH_BITS = 17
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   load,
  input  logic                   blank_lz,
  input  logic [DIGITS-1:0]      dp_mask,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]             brightness,
`endif
  output logic                   busy,
  output logic [DIGITS-1:0]      anode_signals,
  output logic [6:0]             display_out,
  output logic                   dp_out
);

  localparam int BW = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(VALUE_WIDTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  function automatic logic [31:0] max_val();
    logic [31:0] m;
    m = 32'd1;
    for (int i = 0; i < DIGITS; i++) m = m * 32'd10;
    return m - 32'd1;
  endfunction

  localparam logic [31:0] MAX_VAL = max_val();

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [VALUE_WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]           bcd_q, bcd_d;
  logic [BW-1:0]           adj;
  logic                    ovf_pend_q, ovf_pend_d;
  logic [BW-1:0]           digits_q, digits_d;
  logic                    ovf_q, ovf_d;
  logic [REFRESH_BITS-1:0] presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0]       anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [DIGITS-1:0]       sel;
  logic [BW-1:0]           upper;
  logic [3:0]              cur;
  logic                    blank;
  logic                    active;

  assign busy          = (state_q != IDLE);
  assign anode_signals = anode_q;
  assign display_out   = seg_q;
  assign dp_out        = dp_q;

  // Conversion FSM: capture, double-dabble shifts, atomic commit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    adj        = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d    = CONVERT;
          bin_d      = value;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (32'(value) > MAX_VAL);
        end
      end
      CONVERT: begin
        bcd_d = {adj[BW-2:0], bin_q[VALUE_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(VALUE_WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        digits_d = bcd_q;
        ovf_d    = ovf_pend_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running prescaler; scan index steps down on each wrap.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (&presc_q) begin
      idx_d = (idx_q == '0) ? IW'(DIGITS - 1) : idx_q - 1'b1;
    end
  end

  // Segment, anode and point values for the currently scanned digit.
  always_comb begin
    sel    = DIGITS'(1) << idx_q;
    cur    = digits_q[{idx_q, 2'b00} +: 4];
    upper  = digits_q >> {idx_q, 2'b00};
    blank  = blank_lz && (idx_q != '0) && (upper == '0);
    active = 1'b1;
`ifdef BRIGHTNESS_PWM_EN
    active = (presc_q[REFRESH_BITS-1 -: 4] <= brightness);
`endif
    anode_d = '1;
    seg_d   = 7'b1111111;
    dp_d    = 1'b1;
    if (ovf_q) begin
      seg_d = 7'b1111110;
      if (active) anode_d = ~sel;
    end else if (blank) begin
      dp_d = ~dp_mask[idx_q];
    end else begin
      seg_d = seg7(cur);
      dp_d  = ~dp_mask[idx_q];
      if (active) anode_d = ~sel;
    end
  end

  // Conversion state and committed digit register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
    end
  end

  // Scan timing and registered display outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= IW'(DIGITS - 1);
      anode_q <= '1;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

endmodule

// File: doc/multi_digit_display_driver.md
MULTI_DIGIT_DISPLAY_DRIVER -- requirements
Module: multi_digit_display_driver

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digits (legal range 2..8).
REQ-002 The block SHALL have parameter VALUE_WIDTH, default 14, meaning the width of the binary value to display (legal range 4..27).
REQ-003 The block SHALL have parameter REFRESH_BITS, default 17, meaning the width of the scan prescaler; one digit slot lasts 2^REFRESH_BITS clocks.
REQ-004 The block SHALL have port clock, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port value, input, width VALUE_WIDTH: the unsigned binary number to display.
REQ-007 The block SHALL have port load, input, width 1: a one-cycle strobe that requests conversion of value.
REQ-008 The block SHALL have port blank_lz, input, width 1: when high, leading zeros are blanked.
REQ-009 The block SHALL have port dp_mask, input, width DIGITS: decimal-point enables, with bit i belonging to the digit on anode i.
REQ-010 The block SHALL have port busy, output, width 1: high while a conversion is in progress.
REQ-011 The block SHALL have port anode_signals, output, width DIGITS: active-low digit enables; bit DIGITS-1 drives the leftmost (most significant) digit.
REQ-012 The block SHALL have port display_out, output, width 7: active-low segments a..g, with a as the MSB.
REQ-013 The block SHALL have port dp_out, output, width 1: the active-low decimal point.

Function
REQ-014 A load that arrives while busy is low SHALL capture value and raise busy on the next edge.
REQ-015 A load that arrives while busy is high SHALL be ignored.
REQ-016 Conversion SHALL be a sequential shift-and-add-3 (double-dabble) taking exactly VALUE_WIDTH cycles of state CONVERT, followed by one cycle of state COMMIT.
REQ-017 The state machine SHALL have three states: IDLE->CONVERT on an accepted load; CONVERT->COMMIT after VALUE_WIDTH shifts; COMMIT->IDLE unconditionally.
REQ-018 busy SHALL be high in CONVERT and COMMIT and low in IDLE.
REQ-019 The displayed BCD digit register SHALL update atomically in COMMIT only; the display shows the previous value until that point.
REQ-020 Load-to-display latency SHALL be VALUE_WIDTH+2 cycles.
REQ-021 If value > 10^DIGITS-1, COMMIT SHALL store the overflow flag, and every digit SHALL then show a dash (display_out=1111110) with dp_out=1.
REQ-022 The prescaler SHALL count freely; on its wrap to 0 the scan index SHALL advance from DIGITS-1 down to 0, wrapping from 0 back to DIGITS-1.
REQ-023 anode_signals, display_out and dp_out SHALL be registered and SHALL change together one cycle after the scan index changes; exactly one anode bit is low at a time, except when the scanned digit is blanked, in which case all anode bits are high.
REQ-024 Digit encoding SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; any other code SHALL produce 1111111.
REQ-025 With blank_lz high, each digit more significant than the highest nonzero digit SHALL be blanked; digit 0 SHALL never be blanked.
REQ-026 A blanked digit SHALL still show its decimal point if its dp_mask bit is set.
REQ-027 blank_lz and dp_mask SHALL be sampled live each slot and SHALL not require a load.

Reset
REQ-028 On reset low, the outputs SHALL asynchronously take these values: anode_signals all 1s, display_out=1111111, dp_out=1 and busy=0.
REQ-029 On reset low, the FSM SHALL go to IDLE, the prescaler and the digit register SHALL clear to 0, the scan index SHALL go to DIGITS-1, and the overflow flag SHALL clear.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion, and no COMMIT SHALL follow.
REQ-031 After reset deasserts, the first slot SHALL show 0 on digit 0, with the other digits showing 0, or blank when blank_lz is high.

Configuration
REQ-032 Macro BRIGHTNESS_PWM_EN, when defined, SHALL add input brightness [3:0].
REQ-033 With BRIGHTNESS_PWM_EN defined, the active anode SHALL be low only while the prescaler's top 4 bits are <= brightness, so that brightness 15 gives full duty and brightness 0 gives 1/16 duty; segments SHALL be unchanged.
REQ-034 With BRIGHTNESS_PWM_EN undefined, the brightness port SHALL be absent and the active anode SHALL be low for the whole slot.

Verification (DIGITS=4, VALUE_WIDTH=14, REFRESH_BITS=4)
REQ-035 Scenario: reset low, then release, no load -> anodes cycle 0111, 1011, 1101, 1110 every 16 clocks, each showing 0000001, with busy=0 throughout.
REQ-036 Scenario: load value=1234 -> busy high for 15 cycles, digits show 1, 2, 3, 4 from leftmost to rightmost starting on cycle 16; a second load issued during busy is ignored.
REQ-037 Scenario: value=7 with blank_lz=1 and dp_mask=0100 -> three leftmost anodes stay high except that the slot for anode 2 pulses dp_out=0; the rightmost digit shows 0001111.
REQ-038 Scenario: value=10000 -> all four digits show 1111110.
REQ-039 Scenario: reset pulse in CONVERT cycle 5 -> busy=0 immediately, and the display shows 0.
REQ-040 Scenario: with BRIGHTNESS_PWM_EN defined and brightness=3 -> the active anode is low for 4 of 16 clocks per slot.
